// File: rtl/pkt_route_ctrl_if.sv
// pkt_route_ctrl_if - flit handshake bundle for the route controller.
//   fin_*  : flit input from the upstream input datapath (valid/ready, vc id, flit)
//   fout_* : flit output towards the five router ports, one-hot valid per port
//            (0 LOCAL, 1 NORTH, 2 SOUTH, 3 EAST, 4 WEST), per-port ready
// master : the side that feeds flits in and consumes the routed output
// slave  : the route controller itself
interface pkt_route_ctrl_if #(
  parameter int FLIT_WIDTH = 34,
  parameter int N_VIRT_CHN = 3
);
  localparam int VC_WIDTH = (N_VIRT_CHN > 2) ? $clog2(N_VIRT_CHN) : 1;

  logic                  fin_valid_i;
  logic                  fin_ready_o;
  logic [VC_WIDTH-1:0]   fin_vc_id_i;
  logic [FLIT_WIDTH-1:0] fin_data_i;

  logic [4:0]            fout_valid_o;
  logic [4:0]            fout_ready_i;
  logic [VC_WIDTH-1:0]   fout_vc_id_o;
  logic [FLIT_WIDTH-1:0] fout_data_o;

  modport master (
    output fin_valid_i, fin_vc_id_i, fin_data_i, fout_ready_i,
    input  fin_ready_o, fout_valid_o, fout_vc_id_o, fout_data_o
  );

  modport slave (
    input  fin_valid_i, fin_vc_id_i, fin_data_i, fout_ready_i,
    output fin_ready_o, fout_valid_o, fout_vc_id_o, fout_data_o
  );
endinterface

// File: rtl/pkt_route_ctrl.sv
// pkt_route_ctrl - per-VC wormhole route controller with XY routing and a
// single output register stage.
//   clk       : clock
//   arst      : asynchronous active-low reset
//   bus       : pkt_route_ctrl_if.slave (flit in / routed flit out)
//   err_o     : sticky protocol error flag
//   err_clr_i : synchronous clear of err_o (a same-cycle new error wins)
// Build option: define RAVENOC_ROUTE_CHECK_EN to compile in the protocol
// checker (orphan BODY/TAIL dropped, heads on locked VCs flagged). Without
// it err_o is tied 0, orphans go to LOCAL and heads silently relock.
module pkt_route_ctrl #(
  parameter int FLIT_WIDTH = 34,
  parameter int N_VIRT_CHN = 3,
  parameter int X_WIDTH    = 2,
  parameter int Y_WIDTH    = 2,
  parameter int ROUTER_X   = 0,
  parameter int ROUTER_Y   = 0
) (
  input  logic                   clk,
  input  logic                   arst,
  pkt_route_ctrl_if.slave        bus,
  output logic                   err_o,
  input  logic                   err_clr_i
);
  localparam int VC_WIDTH = (N_VIRT_CHN > 2) ? $clog2(N_VIRT_CHN) : 1;
  localparam int VC_DEPTH = 1 << VC_WIDTH;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [1:0] FT_HEAD      = 2'b00;
  localparam logic [1:0] FT_BODY      = 2'b01;
  localparam logic [1:0] FT_TAIL      = 2'b10;
  localparam logic [1:0] FT_HEAD_TAIL = 2'b11;

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NORTH = 3'd1;
  localparam logic [2:0] PORT_SOUTH = 3'd2;
  localparam logic [2:0] PORT_EAST  = 3'd3;
  localparam logic [2:0] PORT_WEST  = 3'd4;

  // Per-VC lock state and stored output port
  logic [0:0]            vc_state [VC_DEPTH];
  logic [2:0]            vc_port  [VC_DEPTH];

  // Output register stage
  logic                  out_full;
  logic [FLIT_WIDTH-1:0] out_data;
  logic [VC_WIDTH-1:0]   out_vc;
  logic [2:0]            out_port;

  logic [1:0]            flit_type;
  logic [X_WIDTH-1:0]    dest_x;
  logic [Y_WIDTH-1:0]    dest_y;
  logic [2:0]            route_port;
  logic [0:0]            cur_state;
  logic [2:0]            cur_port;
  logic [0:0]            nxt_state;
  logic [2:0]            sel_port;
  logic                  store_port;
  logic                  orphan;
  logic                  proto_err;
  logic                  fwd;
  logic                  accept;
  logic                  drain;

  assign flit_type = bus.fin_data_i[FLIT_WIDTH-1 -: 2];
  assign dest_x    = bus.fin_data_i[FLIT_WIDTH-3 -: X_WIDTH];
  assign dest_y    = bus.fin_data_i[FLIT_WIDTH-3-X_WIDTH -: Y_WIDTH];
  assign cur_state = vc_state[bus.fin_vc_id_i];
  assign cur_port  = vc_port[bus.fin_vc_id_i];

  // XY dimension-order routing: resolve X first, then Y
  always_comb begin
    route_port = PORT_LOCAL;
    if (dest_x > X_WIDTH'(ROUTER_X))      route_port = PORT_EAST;
    else if (dest_x < X_WIDTH'(ROUTER_X)) route_port = PORT_WEST;
    else if (dest_y > Y_WIDTH'(ROUTER_Y)) route_port = PORT_NORTH;
    else if (dest_y < Y_WIDTH'(ROUTER_Y)) route_port = PORT_SOUTH;
  end

  always_comb begin
    sel_port   = route_port;
    nxt_state  = cur_state;
    store_port = 1'b0;
    orphan     = 1'b0;
    proto_err  = 1'b0;
    case (flit_type)
      FT_HEAD: begin
        nxt_state  = ST_LOCKED;
        store_port = 1'b1;
        proto_err  = (cur_state == ST_LOCKED);
      end
      FT_HEAD_TAIL: begin
        nxt_state = ST_IDLE;
        proto_err = (cur_state == ST_LOCKED);
      end
      FT_BODY: begin
        if (cur_state == ST_LOCKED) begin
          sel_port = cur_port;
        end else begin
          sel_port  = PORT_LOCAL;
          orphan    = 1'b1;
          proto_err = 1'b1;
        end
      end
      default: begin // FT_TAIL
        if (cur_state == ST_LOCKED) begin
          sel_port  = cur_port;
          nxt_state = ST_IDLE;
        end else begin
          sel_port  = PORT_LOCAL;
          orphan    = 1'b1;
          proto_err = 1'b1;
        end
      end
    endcase
  end

`ifdef RAVENOC_ROUTE_CHECK_EN
  // Orphan BODY/TAIL are consumed but never reach the output register
  assign fwd = ~orphan;

  logic err_q;
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)                       err_q <= 1'b0;
    else if (accept && proto_err)    err_q <= 1'b1;
    else if (err_clr_i)              err_q <= 1'b0;
  end
  assign err_o = err_q;
`else
  assign fwd   = 1'b1;
  assign err_o = 1'b0;
  logic unused_chk;
  assign unused_chk = err_clr_i | orphan | proto_err;
`endif

  // Register may drain and refill in the same cycle
  assign drain           = out_full & bus.fout_ready_i[out_port];
  assign bus.fin_ready_o = ~out_full | bus.fout_ready_i[out_port];
  assign accept          = bus.fin_valid_i & bus.fin_ready_o;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int unsigned i = 0; i < VC_DEPTH; i++) begin
        vc_state[i] <= ST_IDLE;
        vc_port[i]  <= '0;
      end
    end else if (accept) begin
      vc_state[bus.fin_vc_id_i] <= nxt_state;
      if (store_port) vc_port[bus.fin_vc_id_i] <= route_port;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      out_full <= 1'b0;
      out_data <= '0;
      out_vc   <= '0;
      out_port <= '0;
    end else if (accept && fwd) begin
      out_full <= 1'b1;
      out_data <= bus.fin_data_i;
      out_vc   <= bus.fin_vc_id_i;
      out_port <= sel_port;
    end else if (drain) begin
      out_full <= 1'b0;
    end
  end

  assign bus.fout_valid_o = out_full ? (5'b00001 << out_port) : '0;
  assign bus.fout_data_o  = out_data;
  assign bus.fout_vc_id_o = out_vc;
endmodule

// File: tb/tb_pkt_route_ctrl.sv
module tb_pkt_route_ctrl;
  localparam int FW = 34;

  localparam logic [1:0] T_H  = 2'b00;
  localparam logic [1:0] T_B  = 2'b01;
  localparam logic [1:0] T_T  = 2'b10;

  localparam logic [4:0] P_LOCAL = 5'b00001;
  localparam logic [4:0] P_NORTH = 5'b00010;
  localparam logic [4:0] P_EAST  = 5'b01000;
  localparam logic [4:0] P_WEST  = 5'b10000;

`ifdef RAVENOC_ROUTE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst = 1'b0;
  logic err_clr_i = 1'b0;
  logic err_o;

  pkt_route_ctrl_if #(.FLIT_WIDTH(FW), .N_VIRT_CHN(3)) bus ();

  pkt_route_ctrl #(
    .FLIT_WIDTH(FW), .N_VIRT_CHN(3), .X_WIDTH(2), .Y_WIDTH(2),
    .ROUTER_X(1), .ROUTER_Y(1)
  ) dut (
    .clk(clk), .arst(arst), .bus(bus), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [1:0]    q_vc   [$];
  logic [FW-1:0] q_data [$];
  logic [4:0]    q_exp  [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] flit(input logic [1:0] t, input logic [1:0] x,
                                         input logic [1:0] y, input logic [27:0] p);
    return {t, x, y, p};
  endfunction

  // Set inputs, then wait to the sampling point (falling edge)
  task automatic drive(input logic v, input logic [1:0] vc, input logic [FW-1:0] d);
    bus.fin_valid_i = v;
    bus.fin_vc_id_i = vc;
    bus.fin_data_i  = d;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] vc, input logic [FW-1:0] d, input logic [4:0] exp);
    q_vc.push_back(vc);
    q_data.push_back(d);
    q_exp.push_back(exp);
  endtask

  // Stream queued flits back to back with all ready; each flit must appear
  // on its expected port exactly one cycle after acceptance.
  task automatic run_vectors(input string tag);
    int n;
    n = q_data.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) drive(1'b1, q_vc[i], q_data[i]);
      else       drive(1'b0, 2'd0, '0);
      check({tag, " rdy"}, bus.fin_ready_o, 1);
      if (i > 0) begin
        check({tag, " valid"}, bus.fout_valid_o, q_exp[i-1]);
        if (q_exp[i-1] != 5'b0) begin
          check({tag, " data"}, bus.fout_data_o, q_data[i-1]);
          check({tag, " vc"}, bus.fout_vc_id_o, q_vc[i-1]);
        end
      end
      tick();
    end
    drive(1'b0, 2'd0, '0);
    check({tag, " empty"}, bus.fout_valid_o, 0);
    tick();
    q_vc.delete();
    q_data.delete();
    q_exp.delete();
  endtask

  initial begin
    logic [FW-1:0] h, b1, t1;
    bus.fin_valid_i  = 1'b0;
    bus.fin_vc_id_i  = '0;
    bus.fin_data_i   = '0;
    bus.fout_ready_i = 5'h1F;

    // Reset state
    @(negedge clk);
    check("rst valid", bus.fout_valid_o, 0);
    check("rst data", bus.fout_data_o, 0);
    check("rst vc", bus.fout_vc_id_o, 0);
    check("rst err", err_o, 0);
    arst = 1'b1;
    tick();
    drive(1'b0, 2'd0, '0);
    check("rst rdy", bus.fin_ready_o, 1);
    tick();

    // Single packet VC0 to (3,0) -> EAST
    add(2'd0, flit(T_H, 2'd3, 2'd0, 28'h0A00001), P_EAST);
    add(2'd0, flit(T_B, 2'd0, 2'd0, 28'h0B00002), P_EAST);
    add(2'd0, flit(T_B, 2'd1, 2'd2, 28'h0B00003), P_EAST);
    add(2'd0, flit(T_T, 2'd0, 2'd3, 28'h0C00004), P_EAST);
    run_vectors("east pkt");

    // Interleaved VC1 -> LOCAL and VC2 -> WEST; body dest bits are junk
    add(2'd1, flit(T_H, 2'd1, 2'd1, 28'h1100001), P_LOCAL);
    add(2'd2, flit(T_H, 2'd0, 2'd1, 28'h2200001), P_WEST);
    add(2'd1, flit(T_B, 2'd3, 2'd3, 28'h1100002), P_LOCAL);
    add(2'd2, flit(T_B, 2'd3, 2'd3, 28'h2200002), P_WEST);
    add(2'd1, flit(T_T, 2'd3, 2'd0, 28'h1100003), P_LOCAL);
    add(2'd2, flit(T_T, 2'd2, 2'd2, 28'h2200003), P_WEST);
    run_vectors("interleave");

    // Head on a locked VC relocks to the new route
    add(2'd1, flit(T_H, 2'd3, 2'd0, 28'h3300001), P_EAST);
    add(2'd1, flit(T_H, 2'd0, 2'd1, 28'h3300002), P_WEST);
    add(2'd1, flit(T_T, 2'd2, 2'd2, 28'h3300003), P_WEST);
    run_vectors("relock");
    drive(1'b0, 2'd0, '0);
    check("relock err", err_o, CHK);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    drive(1'b0, 2'd0, '0);
    check("relock err clr", err_o, 0);
    tick();

    // Stall: EAST not ready for 3 cycles while a body waits
    h  = flit(T_H, 2'd3, 2'd0, 28'h4400001);
    b1 = flit(T_B, 2'd0, 2'd0, 28'h4400002);
    t1 = flit(T_T, 2'd0, 2'd0, 28'h4400003);
    drive(1'b1, 2'd0, h);
    check("stall h rdy", bus.fin_ready_o, 1);
    tick();
    bus.fout_ready_i = 5'b10111;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'd0, b1);
      check("stall rdy", bus.fin_ready_o, 0);
      check("stall valid", bus.fout_valid_o, P_EAST);
      check("stall data", bus.fout_data_o, h);
      tick();
    end
    bus.fout_ready_i = 5'h1F;
    drive(1'b1, 2'd0, b1);
    check("release rdy", bus.fin_ready_o, 1);
    check("release data", bus.fout_data_o, h);
    tick();
    drive(1'b1, 2'd0, t1);
    check("refill valid", bus.fout_valid_o, P_EAST);
    check("refill data", bus.fout_data_o, b1);
    tick();
    drive(1'b0, 2'd0, '0);
    check("tail data", bus.fout_data_o, t1);
    tick();
    drive(1'b0, 2'd0, '0);
    check("stall empty", bus.fout_valid_o, 0);
    tick();

    // Orphan BODY on idle VC0
    drive(1'b1, 2'd0, flit(T_B, 2'd3, 2'd0, 28'h5500001));
    tick();
    drive(1'b0, 2'd0, '0);
    check("orphan valid", bus.fout_valid_o, CHK ? 5'b0 : P_LOCAL);
    check("orphan err", err_o, CHK);
    tick();
    drive(1'b0, 2'd0, '0);
    check("orphan err sticky", err_o, CHK);
    // New error in the same cycle as clear: set wins
    err_clr_i = 1'b1;
    bus.fin_valid_i = 1'b1;
    bus.fin_data_i  = flit(T_T, 2'd0, 2'd0, 28'h5500002);
    tick();
    err_clr_i = 1'b0;
    drive(1'b0, 2'd0, '0);
    check("set over clr", err_o, CHK);
    tick();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    drive(1'b0, 2'd0, '0);
    check("err clr", err_o, 0);
    tick();

    // Reset mid-packet after HEAD to NORTH
    drive(1'b1, 2'd0, flit(T_H, 2'd1, 2'd3, 28'h6600001));
    tick();
    drive(1'b0, 2'd0, '0);
    check("north valid", bus.fout_valid_o, P_NORTH);
    #2 arst = 1'b0;
    #1;
    check("midrst valid", bus.fout_valid_o, 0);
    check("midrst data", bus.fout_data_o, 0);
    @(negedge clk);
    arst = 1'b1;
    tick();
    drive(1'b1, 2'd0, flit(T_B, 2'd0, 2'd0, 28'h6600002));
    check("postrst rdy", bus.fin_ready_o, 1);
    tick();
    drive(1'b0, 2'd0, '0);
    check("postrst valid", bus.fout_valid_o, CHK ? 5'b0 : P_LOCAL);
    check("postrst err", err_o, CHK);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_route_ctrl.md
PKT_ROUTE_CTRL -- requirements
Module: pkt_route_ctrl

Interface
REQ-001 The block SHALL have parameter FLIT_WIDTH, default 34, flit width including the 2-bit type field in bits [FLIT_WIDTH-1:FLIT_WIDTH-2].
REQ-002 The block SHALL have parameter N_VIRT_CHN, default 3, number of virtual channels; VC_WIDTH = max(1, clog2(N_VIRT_CHN)).
REQ-003 The block SHALL have parameters X_WIDTH and Y_WIDTH, default 2 each, destination coordinate widths.
REQ-004 The block SHALL have parameters ROUTER_X and ROUTER_Y, default 0 each, coordinates of this router.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-006 The block SHALL have port arst, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have ports fin_valid_i (input, 1), fin_ready_o (output, 1), fin_vc_id_i (input, VC_WIDTH) and fin_data_i (input, FLIT_WIDTH) forming the flit input from the upstream input datapath.
REQ-008 The block SHALL have ports fout_valid_o (output, 5, one-hot), fout_ready_i (input, 5), fout_vc_id_o (output, VC_WIDTH) and fout_data_o (output, FLIT_WIDTH) forming the flit output; the index order is 0 LOCAL, 1 NORTH, 2 SOUTH, 3 EAST, 4 WEST.
REQ-009 The block SHALL have port err_o, output, 1 bit, a sticky protocol error flag.
REQ-010 The block SHALL have port err_clr_i, input, 1 bit, a synchronous clear for err_o.

Function
REQ-011 Flit type encoding SHALL be 00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL.
REQ-012 The head destination SHALL be taken from fin_data_i[FLIT_WIDTH-3 -: X_WIDTH] for X, with Y in the next lower Y_WIDTH bits.
REQ-013 Routing SHALL be XY: dest_x > ROUTER_X gives EAST; dest_x < ROUTER_X gives WEST; otherwise dest_y > ROUTER_Y gives NORTH, dest_y < ROUTER_Y gives SOUTH; all equal gives LOCAL.
REQ-014 Each VC SHALL hold an independent state, IDLE or LOCKED, plus a stored 3-bit port.
REQ-015 An accepted HEAD SHALL compute the port from its destination, store it, and move the VC to LOCKED.
REQ-016 An accepted BODY on a LOCKED VC SHALL use the stored port, and the state SHALL be unchanged.
REQ-017 An accepted TAIL on a LOCKED VC SHALL use the stored port and return the VC to IDLE.
REQ-018 An accepted HEAD_TAIL SHALL use the computed port and leave the VC state unchanged when IDLE.
REQ-019 A flit SHALL be accepted when fin_valid_i and fin_ready_o are both 1.
REQ-020 A single output register stage SHALL hold data, vc_id and port; latency from acceptance to fout_valid_o SHALL be exactly 1 cycle.
REQ-021 fin_ready_o SHALL equal (output register empty) OR (fout_ready_i[held port] = 1), so that the register drains and refills in the same cycle.
REQ-022 fout_valid_o SHALL be one-hot on the held port while the register is full, and all-zero when it is empty.
REQ-023 Output data SHALL be held stable while fout_valid_o is nonzero and the matching fout_ready_i is 0.
REQ-024 VCs SHALL interleave freely; a tail on VC a SHALL NOT affect the lock on VC b.
REQ-025 When err_clr_i is 1 in the same cycle as a new error, the set SHALL take priority over the clear.

Reset
REQ-026 While arst is 0, all VCs SHALL be IDLE, stored ports SHALL be 0, the output register SHALL be empty, fout_valid_o SHALL be 0, fout_data_o and fout_vc_id_o SHALL be 0, err_o SHALL be 0, and fin_ready_o SHALL be 1 after deassertion.
REQ-027 Reset asserted mid-packet SHALL discard all locks; a following BODY is treated per REQ-029 or REQ-030.

Configuration
REQ-028 The macro RAVENOC_ROUTE_CHECK_EN SHALL select whether the protocol checker is compiled in.
REQ-029 With RAVENOC_ROUTE_CHECK_EN defined:
- a BODY or TAIL on an IDLE VC SHALL be accepted, dropped (not forwarded) and set err_o;
- a HEAD or HEAD_TAIL on a LOCKED VC SHALL set err_o and be processed as a new head (relock, or unlock for HEAD_TAIL).
REQ-030 Without RAVENOC_ROUTE_CHECK_EN:
- err_o SHALL be tied 0;
- a BODY or TAIL on an IDLE VC SHALL be forwarded to LOCAL;
- a head on a LOCKED VC SHALL silently relock.

Verification
REQ-031 Router (1,1): HEAD dest (3,0) on VC0, two BODY, then TAIL, all fout_ready_i=1 -> four flits on EAST (fout_valid_o=5'b01000), one per cycle, each 1 cycle after acceptance; VC0 is IDLE afterwards.
REQ-032 Router (1,1): HEAD dest (1,1) on VC1 interleaved with HEAD dest (0,1) on VC2, then alternating bodies/tails -> VC1 flits go to LOCAL and VC2 flits go to WEST, no cross-contamination.
REQ-033 Stall: EAST ready held 0 for 3 cycles with a full register -> fin_ready_o=0 and fout_data_o stable for 3 cycles; ready=1 -> drain and refill in the same cycle, no bubble.
REQ-034 With RAVENOC_ROUTE_CHECK_EN: BODY on IDLE VC0 -> no fout_valid_o, err_o=1 the next cycle, err_o stays 1 until err_clr_i pulses.
REQ-035 Reset mid-packet: arst low after the HEAD to NORTH, then a BODY -> BODY is dropped with err_o=1 (macro defined) or goes to LOCAL (macro undefined).
